// File: rtl/regfile_mp_if.sv
// Bundles the decode/writeback side of regfile_mp: read ports, write ports,
// allocation request and the scoreboard vector.
interface regfile_mp_if #(
    parameter int DW       = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic [NUM_WR-1:0]    wr_en;
    logic [NUM_WR*AW-1:0] wr_addr;
    logic [NUM_WR*DW-1:0] wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic [NUM_REGS-1:0]  busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and busy scoreboard.
// Combinational reads, one-edge write/scoreboard update, no backpressure;
// optional hardwired zero register under REGFILE_ZERO_REG_EN.
module regfile_mp #(
    parameter int DW       = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave rf
);
    // Lowest register index that accepts writes, allocs and bypass.
`ifdef REGFILE_ZERO_REG_EN
    localparam int FIRST_REG = 1;
`else
    localparam int FIRST_REG = 0;
`endif

    logic [DW-1:0]        mem_q [NUM_REGS];
    logic [DW-1:0]        mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic [NUM_RD*DW-1:0] rd_data_c;
    logic [NUM_RD-1:0]    rd_busy_c;

    // Ascending port order lets the highest-index port win; allocs land last.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int r = FIRST_REG; r < NUM_REGS; r++) begin
                if (rf.wr_en[w] && rf.wr_addr[w*AW +: AW] == AW'(r)) begin
                    mem_d[r]  = rf.wr_data[w*DW +: DW];
                    busy_d[r] = 1'b0;
                end
            end
        end
        for (int r = FIRST_REG; r < NUM_REGS; r++) begin
            if (rf.alloc_en && rf.alloc_addr == AW'(r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            logic byp_ok;
            byp_ok = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (rf.rd_addr[p*AW +: AW] == AW'(r)) begin
                    rd_data_c[p*DW +: DW] = mem_q[r];
                    rd_busy_c[p]          = busy_q[r];
                end
            end
            // Only in-range, writable addresses may be bypassed.
            for (int r = FIRST_REG; r < NUM_REGS; r++) begin
                if (rf.rd_addr[p*AW +: AW] == AW'(r)) begin
                    byp_ok = 1'b1;
                end
            end
            for (int w = 0; w < NUM_WR; w++) begin
                if (byp_ok && rf.wr_en[w] &&
                    rf.wr_addr[w*AW +: AW] == rf.rd_addr[p*AW +: AW]) begin
                    rd_data_c[p*DW +: DW] = rf.wr_data[w*DW +: DW];
                    rd_busy_c[p]          = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= DW'(r);
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign rf.rd_data  = rd_data_c;
    assign rf.rd_busy  = rd_busy_c;
    assign rf.busy_vec = busy_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default 32x32 instance plus a small
// 20-entry instance that exercises out-of-range addresses.
module tb_regfile_mp;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    regfile_mp_if #(.DW(32), .NUM_REGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) rf ();
    regfile_mp_if #(.DW(8),  .NUM_REGS(20), .AW(5), .NUM_RD(1), .NUM_WR(1)) rf2 ();

    regfile_mp #(.DW(32), .NUM_REGS(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    regfile_mp #(.DW(8), .NUM_REGS(20), .AW(5), .NUM_RD(1), .NUM_WR(1)) dut_small (
        .clk (clk),
        .rst (rst),
        .rf  (rf2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then move 1 ns past it before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.wr_en       = '0;
        rf.wr_addr     = '0;
        rf.wr_data     = '0;
        rf.alloc_en    = 1'b0;
        rf.alloc_addr  = '0;
        rf2.wr_en      = '0;
        rf2.wr_addr    = '0;
        rf2.wr_data    = '0;
        rf2.alloc_en   = 1'b0;
        rf2.alloc_addr = '0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        rf.rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        rf.rd_addr  = '0;
        rf2.rd_addr = '0;
        tick();
        rst = 1'b0;

        // Reset values
        rd(5'd7, 5'd31);
        check("rst_rd7",   rf.rd_data[31:0],  64'h7);
        check("rst_rd31",  rf.rd_data[63:32], 64'h1F);
        check("rst_busy",  rf.busy_vec,       64'h0);
        check("rst_rdbsy", rf.rd_busy,        64'h0);

        // Write with same-cycle bypass, seen on both read ports
        rf.wr_en   = 2'b01;
        rf.wr_addr = {5'd0, 5'd3};
        rf.wr_data = {32'h0, 32'hDEADBEEF};
        rd(5'd3, 5'd3);
        check("byp_p0", rf.rd_data[31:0],  64'hDEADBEEF);
        check("byp_p1", rf.rd_data[63:32], 64'hDEADBEEF);
        tick();
        idle();
        rd(5'd3, 5'd4);
        check("wr_stored3", rf.rd_data[31:0],  64'hDEADBEEF);
        check("untouched4", rf.rd_data[63:32], 64'h4);
        tick();
        rd(5'd3, 5'd4);
        check("wr_held3", rf.rd_data[31:0], 64'hDEADBEEF);

        // Dual-write collision: port 1 wins, in bypass and in storage
        rf.wr_en   = 2'b11;
        rf.wr_addr = {5'd5, 5'd5};
        rf.wr_data = {32'h22222222, 32'h11111111};
        rd(5'd5, 5'd6);
        check("coll_byp", rf.rd_data[31:0], 64'h22222222);
        tick();
        idle();
        rd(5'd5, 5'd6);
        check("coll_store", rf.rd_data[31:0],  64'h22222222);
        check("coll_rd6",   rf.rd_data[63:32], 64'h6);

        // Two ports to different addresses in one cycle
        rf.wr_en   = 2'b11;
        rf.wr_addr = {5'd11, 5'd10};
        rf.wr_data = {32'hBBBB000B, 32'hAAAA000A};
        rd(5'd11, 5'd10);
        check("dual_byp11", rf.rd_data[31:0],  64'hBBBB000B);
        check("dual_byp10", rf.rd_data[63:32], 64'hAAAA000A);
        tick();
        idle();
        rd(5'd10, 5'd11);
        check("dual_st10", rf.rd_data[31:0],  64'hAAAA000A);
        check("dual_st11", rf.rd_data[63:32], 64'hBBBB000B);
        check("dual_busy", rf.busy_vec,       64'h0);

        // Scoreboard: alloc, busy visible, write clears with bypass
        rf.alloc_en   = 1'b1;
        rf.alloc_addr = 5'd9;
        rd(5'd9, 5'd8);
        check("alloc_pre", rf.rd_busy, 64'h0);
        tick();
        idle();
        rd(5'd9, 5'd8);
        check("alloc_vec",   rf.busy_vec, 64'h0000_0200);
        check("alloc_rdbsy", rf.rd_busy,  64'h1);
        rf.wr_en   = 2'b10;
        rf.wr_addr = {5'd9, 5'd0};
        rf.wr_data = {32'hA5A5A5A5, 32'h0};
        rd(5'd9, 5'd9);
        check("clr_rdbsy", rf.rd_busy,        64'h0);
        check("clr_byp",   rf.rd_data[63:32], 64'hA5A5A5A5);
        check("clr_vec_b", rf.busy_vec,       64'h0000_0200);
        tick();
        idle();
        rd(5'd9, 5'd9);
        check("clr_vec_a", rf.busy_vec,       64'h0);
        check("clr_data",  rf.rd_data[31:0],  64'hA5A5A5A5);

        // Alloc and write to the same register: alloc wins on busy
        rf.alloc_en   = 1'b1;
        rf.alloc_addr = 5'd4;
        rf.wr_en      = 2'b01;
        rf.wr_addr    = {5'd0, 5'd4};
        rf.wr_data    = {32'h0, 32'h44440004};
        tick();
        idle();
        rd(5'd4, 5'd9);
        check("aw_vec",   rf.busy_vec,      64'h0000_0010);
        check("aw_data",  rf.rd_data[31:0], 64'h44440004);
        check("aw_rdbsy", rf.rd_busy,       64'h1);

        // Register 0 with write + alloc
        rf.alloc_en   = 1'b1;
        rf.alloc_addr = 5'd0;
        rf.wr_en      = 2'b01;
        rf.wr_addr    = {5'd0, 5'd0};
        rf.wr_data    = {32'h0, 32'hFFFFFFFF};
        rd(5'd0, 5'd4);
`ifdef REGFILE_ZERO_REG_EN
        check("z0_byp", rf.rd_data[31:0], 64'h0);
`else
        check("z0_byp", rf.rd_data[31:0], 64'hFFFFFFFF);
`endif
        tick();
        idle();
        rd(5'd0, 5'd4);
`ifdef REGFILE_ZERO_REG_EN
        check("z0_data", rf.rd_data[31:0], 64'h0);
        check("z0_vec",  rf.busy_vec,      64'h0000_0010);
        check("z0_bsy",  rf.rd_busy,       64'h2);
`else
        check("z0_data", rf.rd_data[31:0], 64'hFFFFFFFF);
        check("z0_vec",  rf.busy_vec,      64'h0000_0011);
        check("z0_bsy",  rf.rd_busy,       64'h3);
`endif

        // Reset beats same-cycle write and alloc, discards prior state
        rst           = 1'b1;
        rf.alloc_en   = 1'b1;
        rf.alloc_addr = 5'd12;
        rf.wr_en      = 2'b11;
        rf.wr_addr    = {5'd7, 5'd0};
        rf.wr_data    = {32'h77777777, 32'hFFFFFFFF};
        tick();
        rst = 1'b0;
        idle();
        rd(5'd0, 5'd7);
        check("mrst_rd0",  rf.rd_data[31:0],  64'h0);
        check("mrst_rd7",  rf.rd_data[63:32], 64'h7);
        check("mrst_busy", rf.busy_vec,       64'h0);
        rd(5'd3, 5'd5);
        check("mrst_rd3", rf.rd_data[31:0],  64'h3);
        check("mrst_rd5", rf.rd_data[63:32], 64'h5);

        // Small instance: in-range reset value, out-of-range read/write/alloc
        rf2.rd_addr = 5'd19;
        #1;
        check("s_rst19", rf2.rd_data, 64'h13);
        rf2.rd_addr    = 5'd25;
        rf2.wr_en      = 1'b1;
        rf2.wr_addr    = 5'd25;
        rf2.wr_data    = 8'h5A;
        rf2.alloc_en   = 1'b1;
        rf2.alloc_addr = 5'd25;
        #1;
        check("s_oor_byp",  rf2.rd_data, 64'h0);
        check("s_oor_bsy",  rf2.rd_busy, 64'h0);
        tick();
        idle();
        #1;
        check("s_oor_rd",   rf2.rd_data,  64'h0);
        check("s_oor_vec",  rf2.busy_vec, 64'h0);
        rf2.alloc_en   = 1'b1;
        rf2.alloc_addr = 5'd19;
        tick();
        idle();
        rf2.rd_addr = 5'd19;
        #1;
        check("s_vec19",  rf2.busy_vec, 64'h8_0000);
        check("s_bsy19",  rf2.rd_busy,  64'h1);
        rf2.wr_en   = 1'b1;
        rf2.wr_addr = 5'd19;
        rf2.wr_data = 8'hC3;
        #1;
        check("s_byp19",  rf2.rd_data, 64'hC3);
        check("s_nbsy19", rf2.rd_busy, 64'h0);
        tick();
        idle();
        #1;
        check("s_st19",   rf2.rd_data,  64'hC3);
        check("s_clr19",  rf2.busy_vec, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the next processor core.
- Supports configurable data width, register count and number of read/write ports.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard so decode can stall on pending writebacks.
- Sits between decode (reads, allocation) and writeback (writes).

Parameters:
- DW, 32: data width in bits.
- NUM_REGS, 32: number of architectural registers (need not be a power of two).
- AW, 5: address width; must satisfy 2**AW >= NUM_REGS.
- NUM_RD, 2: number of read ports.
- NUM_WR, 2: number of write ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port p occupies bits [p*AW +: AW].
- rd_data  out  NUM_RD*DW  read data; port p occupies bits [p*DW +: DW].
- rd_busy  out  NUM_RD  1 = the register addressed by port p has a pending write after bypass.
- wr_en  in  NUM_WR  write enable per write port.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*DW  write data.
- alloc_en  in  1  marks alloc_addr busy (new in-flight producer).
- alloc_addr  in  AW  register to mark busy.
- busy_vec  out  NUM_REGS  registered scoreboard state, bit i = register i busy.

Behaviour:
- Reset: rst sampled high at a rising edge sets register i to i, truncated/zero-extended to DW, for all i. It clears busy_vec to all zeros.
- Reset has priority over any write or alloc in the same cycle. Reset mid-operation discards all in-flight state.
- Writes: on a rising edge with rst=0, each port w with wr_en[w]=1 and wr_addr[w] < NUM_REGS stores wr_data[w].
  - Same address on several ports: the highest-index port wins.
  - Out-of-range addresses (>= NUM_REGS) are ignored.
- Reads are combinational, zero-latency. For each read port p:
  - If any enabled write port targets rd_addr[p] in the current cycle, rd_data[p] = that port's wr_data (highest index wins; bypass).
  - Otherwise rd_data[p] = stored value.
  - Out-of-range read address returns 0, and rd_busy[p] = 0.
- Scoreboard update at the rising edge, rst=0:
  - Each in-range enabled write clears busy_vec[wr_addr[w]].
  - alloc_en=1 with alloc_addr in range sets busy_vec[alloc_addr]. Alloc is applied after the clears, so alloc wins on a same-address collision.
  - An out-of-range alloc is ignored.
- rd_busy[p] = busy_vec[rd_addr[p]] AND NOT (any enabled write to rd_addr[p] this cycle). A write being bypassed therefore reports not busy.
- Writes to a register that is not busy are legal; busy stays 0.
- All ports are independent. No internal state machine beyond the storage array and the scoreboard. No outputs are registered except busy_vec.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 always reads 0 on every read port, including when bypass would apply.
  - Writes to address 0 are ignored and never bypassed.
  - alloc to 0 is ignored; busy_vec[0] and rd_busy for address 0 are always 0.
  - Reset leaves register 0 = 0.
- Undefined: register 0 behaves as every other register (reset value 0, writable, allocatable).

Test Plan (defaults, REGFILE_ZERO_REG_EN undefined unless stated):
- Reset check: assert rst for 1 cycle, then read addr 7 and 31 -> rd_data = 0x00000007 and 0x0000001F; busy_vec = 0.
- Write/bypass: wr_en[0]=1, wr_addr 3, wr_data 0xDEADBEEF, rd_addr[0]=3 in the same cycle -> rd_data[0] = 0xDEADBEEF that cycle and every cycle after.
- Dual-write collision: both ports write addr 5, port0 0x11111111 and port1 0x22222222 -> next-cycle read of 5 = 0x22222222.
- Scoreboard: alloc 9 -> next cycle busy_vec[9]=1 and rd_busy=1 for addr 9. Then write 9 with 0xA5A5A5A5 -> rd_busy=0 and data bypassed that cycle; busy_vec[9]=0 after the edge.
- Alloc/write collision: alloc 4 and write 4 in the same cycle -> busy_vec[4]=1 after the edge, and register 4 holds the written value.
- Zero register (macro defined): write 0 with 0xFFFFFFFF plus alloc 0 -> read 0 returns 0, busy_vec[0]=0; same stimulus with rst high the same cycle -> all registers back to reset values.
